src_ctrl_seq: RTL and testbench
===============================

Name: src_ctrl_seq

Overview:
Parametrised sequencing controller for the multi-stage upsampler datapath.
- Keeps the 8-state ALLOC..PC_INCREMENT flow.
- Owns its own tap, stage, vector and channel counters, so no externally generated pass/last flags are needed.
- Adds valid/ready handshakes toward the audio input bus and the output sample sink.
- Sits between the allocation list/regfile/MAC datapath and the audio bus; drives indices and MAC strobes.

Parameters:
STAGES, 4, number of cascaded upsampler stages (>=1)
VECTORS, 2, coefficient vectors (polyphase branches) per input sample (>=1)
TAPS, 16, MAC cycles per vector convolution (>=2)
CHANNELS, 2, interleaved audio channels (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  clock enable; all state and counters hold when low
in_valid  in  1  audio bus has a new input sample
in_ready  out  1  controller accepts the input sample this cycle
out_valid  out  1  output sample is presented to the sink
out_ready  in  1  sink accepts the output sample
ostate  out  3  current state
tap_idx  out  TW=$clog2(max(TAPS,2))  coefficient/RAM tap index
stage_idx  out  SW=$clog2(max(STAGES,2))  current stage
vector_idx  out  VW=$clog2(max(VECTORS,2))  current vector
ch_idx  out  CW=$clog2(max(CHANNELS,2))  current channel
mac_clr  out  1  MAC accumulator clear/init strobe
mac_en  out  1  MAC accumulate enable

Behaviour:
- State encoding: ALLOC=0, LOAD_INIT=1, CONV=2, LOAD_RES=3, LOAD_ERR=4, LOAD_OUT=5, LOAD_IN=6, PC_INC=7.
- All transitions and counter updates occur on rising clk only when en=1.
- Reset (asynchronous, any time including mid-CONV or mid-handshake):
  - ostate=ALLOC; all idx=0.
  - in_ready, out_valid, mac_clr and mac_en go to 0 immediately.
- State transitions:
  - ALLOC -> LOAD_INIT.
  - LOAD_INIT -> CONV. mac_clr=1 in LOAD_INIT; tap_idx forced to 0.
  - CONV: mac_en=1; tap_idx increments each enabled cycle. At tap_idx==TAPS-1: go to LOAD_RES and clear tap_idx to 0. CONV lasts exactly TAPS enabled cycles.
  - LOAD_RES -> LOAD_ERR.
  - LOAD_ERR: if stage_idx!=STAGES-1, go to PC_INC and increment stage_idx; otherwise go to LOAD_OUT.
  - LOAD_OUT: out_valid=en. Holds until out_ready=1 with en=1. On that handshake:
    - if vector_idx!=VECTORS-1: go to PC_INC, vector_idx+1, stage_idx=0;
    - otherwise: go to LOAD_IN.
  - LOAD_IN: in_ready=en. Holds until in_valid=1 with en=1. On that handshake: go to PC_INC; stage_idx=0, vector_idx=0; ch_idx increments and wraps from CHANNELS-1 to 0.
  - PC_INC -> ALLOC.
- Handshake rules:
  - A transfer is the cycle where valid&ready&en are all high; exactly one transfer per visit to the state.
  - out_valid and in_ready are Moore outputs gated by en. They never assert outside their own state.
- Outputs: mac_clr and mac_en are combinational from state AND en. idx outputs are registered.
- Latency with zero backpressure:
  - non-last stage: TAPS+5 cycles, ALLOC to ALLOC;
  - last stage, non-last vector: TAPS+6;
  - last vector: TAPS+7.
- Degenerate parameter values:
  - STAGES=1: LOAD_ERR always goes to LOAD_OUT.
  - VECTORS=1: LOAD_OUT always goes to LOAD_IN.
  - CHANNELS=1: ch_idx stays 0.
- Counter widths: no counter ever exceeds its parameter-1. Unused upper codes are unreachable.
- Illegal state (e.g. after an upset): recover to ALLOC on the next enabled clock.

Optional Feature:
SRC_CTRL_FRAME_CNT_EN
- Defined:
  - adds output port frame_cnt [15:0], reset 0;
  - frame_cnt increments on each LOAD_IN transfer where ch_idx==CHANNELS-1 (one complete multichannel frame);
  - wraps from 65535 to 0.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use STAGES=2, VECTORS=2, TAPS=4, CHANNELS=2.
- Reset: assert rst between clock edges while in CONV with tap_idx=2 -> ostate=0, tap/stage/vector/ch_idx=0, mac_en=0 before the next edge.
- Stage pass: en=1 from reset -> ostate sequence 0,1,2,2,2,2,3,4,7,0 (9 cycles); tap_idx 0..3 in CONV; mac_clr only in state 1; stage_idx=1 after PC_INC.
- Output backpressure: reach LOAD_OUT with out_ready=0 for 3 cycles -> ostate stays 5, out_valid=1. Then out_ready=1 -> next ostate=7, vector_idx=1, stage_idx=0.
- Input wait: reach LOAD_IN with in_valid=0 for 5 cycles -> ostate=6, in_ready=1. Then in_valid=1 -> ostate=7, ch_idx=1, vector_idx=0, stage_idx=0. A second full frame returns ch_idx to 0 (frame_cnt=1 if SRC_CTRL_FRAME_CNT_EN).
- Enable gating: drop en for 4 cycles during CONV at tap_idx=1 -> state and tap_idx frozen, mac_en=0. Also drop en in LOAD_OUT with out_ready=1 -> out_valid=0 and no transfer.
- Illegal state: force cstate to an invalid code where synthesis permits, or check via coverage -> ALLOC on the next enabled edge.

Source files
------------

// File: rtl/src_ctrl_seq.sv
// Upsampler sequencer: ALLOC..PC_INC flow with own tap/stage/vector/channel counters; optional frame_cnt via SRC_CTRL_FRAME_CNT_EN.
// Latency ALLOC->ALLOC: TAPS+5 (inner stage), TAPS+6 (last stage), TAPS+7 (last vector), zero backpressure.
// Backpressure: holds in LOAD_OUT until out_ready, in LOAD_IN until in_valid; en=0 freezes everything.
module src_ctrl_seq #(
    parameter int STAGES   = 4,
    parameter int VECTORS  = 2,
    parameter int TAPS     = 16,
    parameter int CHANNELS = 2,
    localparam int TW = $clog2((TAPS > 2) ? TAPS : 2),
    localparam int SW = $clog2((STAGES > 2) ? STAGES : 2),
    localparam int VW = $clog2((VECTORS > 2) ? VECTORS : 2),
    localparam int CW = $clog2((CHANNELS > 2) ? CHANNELS : 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    ostate,
    output logic [TW-1:0] tap_idx,
    output logic [SW-1:0] stage_idx,
    output logic [VW-1:0] vector_idx,
    output logic [CW-1:0] ch_idx,
    output logic          mac_clr,
    output logic          mac_en
`ifdef SRC_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam logic [2:0] ALLOC     = 3'd0;
    localparam logic [2:0] LOAD_INIT = 3'd1;
    localparam logic [2:0] CONV      = 3'd2;
    localparam logic [2:0] LOAD_RES  = 3'd3;
    localparam logic [2:0] LOAD_ERR  = 3'd4;
    localparam logic [2:0] LOAD_OUT  = 3'd5;
    localparam logic [2:0] LOAD_IN   = 3'd6;
    localparam logic [2:0] PC_INC    = 3'd7;

    localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);
    localparam logic [VW-1:0] VEC_LAST   = VW'(VECTORS - 1);
    localparam logic [CW-1:0] CH_LAST    = CW'(CHANNELS - 1);

    logic [2:0]    cstate;
    logic [2:0]    nstate;
    logic [TW-1:0] tap_n;
    logic [SW-1:0] stage_n;
    logic [VW-1:0] vector_n;
    logic [CW-1:0] ch_n;
    logic          in_xfer;

    // Moore handshake/strobe outputs, gated by en so nothing is offered while frozen.
    assign ostate    = cstate;
    assign out_valid = (cstate == LOAD_OUT) && en;
    assign in_ready  = (cstate == LOAD_IN) && en;
    assign mac_clr   = (cstate == LOAD_INIT) && en;
    assign mac_en    = (cstate == CONV) && en;
    assign in_xfer   = in_ready && in_valid;

    always_comb begin
        nstate   = cstate;
        tap_n    = tap_idx;
        stage_n  = stage_idx;
        vector_n = vector_idx;
        ch_n     = ch_idx;
        case (cstate)
            ALLOC: nstate = LOAD_INIT;
            LOAD_INIT: begin
                nstate = CONV;
                tap_n  = '0;
            end
            CONV: begin
                if (tap_idx == TAP_LAST) begin
                    nstate = LOAD_RES;
                    tap_n  = '0;
                end else begin
                    tap_n = tap_idx + 1'b1;
                end
            end
            LOAD_RES: nstate = LOAD_ERR;
            LOAD_ERR: begin
                if (stage_idx != STAGE_LAST) begin
                    nstate  = PC_INC;
                    stage_n = stage_idx + 1'b1;
                end else begin
                    nstate = LOAD_OUT;
                end
            end
            LOAD_OUT: begin
                if (out_ready) begin
                    if (vector_idx != VEC_LAST) begin
                        nstate   = PC_INC;
                        vector_n = vector_idx + 1'b1;
                        stage_n  = '0;
                    end else begin
                        nstate = LOAD_IN;
                    end
                end
            end
            LOAD_IN: begin
                if (in_valid) begin
                    nstate   = PC_INC;
                    stage_n  = '0;
                    vector_n = '0;
                    ch_n     = (ch_idx == CH_LAST) ? '0 : ch_idx + 1'b1;
                end
            end
            PC_INC: nstate = ALLOC;
            default: nstate = ALLOC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cstate     <= ALLOC;
            tap_idx    <= '0;
            stage_idx  <= '0;
            vector_idx <= '0;
            ch_idx     <= '0;
        end else if (en) begin
            cstate     <= nstate;
            tap_idx    <= tap_n;
            stage_idx  <= stage_n;
            vector_idx <= vector_n;
            ch_idx     <= ch_n;
        end
    end

`ifdef SRC_CTRL_FRAME_CNT_EN
    // A frame completes when the last channel's input sample is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (in_xfer && (ch_idx == CH_LAST)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_src_ctrl_seq.sv
// Bench for src_ctrl_seq: directed scenarios plus randomized handshakes against a loop-generated schedule model.
module tb_src_ctrl_seq;
    localparam int S = 2;
    localparam int V = 2;
    localparam int T = 4;
    localparam int C = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] ostate;
    logic [1:0] tap_idx;
    logic [0:0] stage_idx;
    logic [0:0] vector_idx;
    logic [0:0] ch_idx;
    logic       mac_clr;
    logic       mac_en;
`ifdef SRC_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    src_ctrl_seq #(.STAGES(S), .VECTORS(V), .TAPS(T), .CHANNELS(C)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .ostate(ostate), .tap_idx(tap_idx), .stage_idx(stage_idx),
        .vector_idx(vector_idx), .ch_idx(ch_idx),
        .mac_clr(mac_clr), .mac_en(mac_en)
`ifdef SRC_CTRL_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Advance with current inputs until the given state/tap is reached, bounded by budget.
    task automatic wait_for(input int st, input int tap, input int budget);
        int n = 0;
        while (!(ostate == st && tap_idx == tap) && n < budget) begin
            tick();
            n++;
        end
        vecs++;
        if (ostate != st || tap_idx != tap) begin
            errs++;
            $display("FAIL wait_for: ostate=%0d tap=%0d, required ostate=%0d tap=%0d", ostate, tap_idx, st, tap);
        end
    endtask

    task automatic test_reset();
        do_reset();
        en = 1'b1;
        wait_for(2, 2, 20);
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({ostate, tap_idx, stage_idx, vector_idx, ch_idx, mac_en, mac_clr, in_ready, out_valid} !== '0) begin
            errs++;
            $display("FAIL reset_async: ostate=%0d tap=%0d stg=%0d vec=%0d ch=%0d mac_en=%0b, required all 0",
                     ostate, tap_idx, stage_idx, vector_idx, ch_idx, mac_en);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stage_pass();
        int exp_st[10]  = '{0, 1, 2, 2, 2, 2, 3, 4, 7, 0};
        int exp_tap[10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vecs++;
            if (ostate !== exp_st[i] || tap_idx !== exp_tap[i] ||
                mac_clr !== (exp_st[i] == 1) || mac_en !== (exp_st[i] == 2)) begin
                errs++;
                $display("FAIL stage_pass[%0d]: st=%0d tap=%0d clr=%0b en=%0b, required st=%0d tap=%0d",
                         i, ostate, tap_idx, mac_clr, mac_en, exp_st[i], exp_tap[i]);
            end
            if (i < 9) tick();
        end
        vecs++;
        if (stage_idx !== 1'b1) begin
            errs++;
            $display("FAIL stage_pass_stage: stage_idx=%0d, required 1", stage_idx);
        end
    endtask

    task automatic test_out_backpressure();
        out_ready = 1'b0;
        wait_for(5, 0, 20);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (ostate !== 3'd5 || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL out_hold[%0d]: ostate=%0d out_valid=%0b, required 5 and 1", i, ostate, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vecs++;
        if (ostate !== 3'd7 || vector_idx !== 1'b1 || stage_idx !== 1'b0) begin
            errs++;
            $display("FAIL out_xfer: ostate=%0d vec=%0d stg=%0d, required 7 1 0", ostate, vector_idx, stage_idx);
        end
    endtask

    task automatic test_input_wait();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_for(6, 0, 40);
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (ostate !== 3'd6 || in_ready !== 1'b1) begin
                errs++;
                $display("FAIL in_hold[%0d]: ostate=%0d in_ready=%0b, required 6 and 1", i, ostate, in_ready);
            end
            tick();
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vecs++;
        if (ostate !== 3'd7 || ch_idx !== 1'b1 || vector_idx !== 1'b0 || stage_idx !== 1'b0) begin
            errs++;
            $display("FAIL in_xfer: ostate=%0d ch=%0d vec=%0d stg=%0d, required 7 1 0 0",
                     ostate, ch_idx, vector_idx, stage_idx);
        end
        wait_for(6, 0, 80);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        vecs++;
        if (ch_idx !== 1'b0) begin
            errs++;
            $display("FAIL ch_wrap: ch_idx=%0d, required 0", ch_idx);
        end
`ifdef SRC_CTRL_FRAME_CNT_EN
        vecs++;
        if (frame_cnt !== 16'd1) begin
            errs++;
            $display("FAIL frame_cnt: frame_cnt=%0d, required 1", frame_cnt);
        end
`endif
    endtask

    task automatic test_enable_gating();
        do_reset();
        en = 1'b1;
        wait_for(2, 1, 20);
        en = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (ostate !== 3'd2 || tap_idx !== 2'd1 || mac_en !== 1'b0) begin
                errs++;
                $display("FAIL en_freeze[%0d]: ostate=%0d tap=%0d mac_en=%0b, required 2 1 0",
                         i, ostate, tap_idx, mac_en);
            end
            tick();
        end
        en = 1'b1;
        out_ready = 1'b0;
        wait_for(5, 0, 40);
        out_ready = 1'b1;
        en = 1'b0;
        #1;
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL en_out_valid: out_valid=%0b, required 0", out_valid);
        end
        tick();
        vecs++;
        if (ostate !== 3'd5) begin
            errs++;
            $display("FAIL en_no_xfer: ostate=%0d, required 5", ostate);
        end
        en = 1'b1;
        #1;
        vecs++;
        if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL en_out_valid_back: out_valid=%0b, required 1", out_valid);
        end
        tick();
        out_ready = 1'b0;
        vecs++;
        if (ostate !== 3'd7) begin
            errs++;
            $display("FAIL en_xfer: ostate=%0d, required 7", ostate);
        end
    endtask

    typedef struct {
        int st;
        int tap;
        int stg;
        int vec;
        int ch;
    } ent_t;

    ent_t sched[$];
    int   model_ch;
    int   model_frames;

    // One frame of the schedule for one channel, built from nested vector/stage/tap loops.
    task automatic push_frame();
        int nch = (model_ch + 1) % C;
        for (int v = 0; v < V; v++) begin
            for (int s = 0; s < S; s++) begin
                sched.push_back('{0, 0, s, v, model_ch});
                sched.push_back('{1, 0, s, v, model_ch});
                for (int k = 0; k < T; k++) sched.push_back('{2, k, s, v, model_ch});
                sched.push_back('{3, 0, s, v, model_ch});
                sched.push_back('{4, 0, s, v, model_ch});
                if (s < S - 1) begin
                    sched.push_back('{7, 0, s + 1, v, model_ch});
                end else begin
                    sched.push_back('{5, 0, s, v, model_ch});
                    if (v < V - 1) begin
                        sched.push_back('{7, 0, 0, v + 1, model_ch});
                    end else begin
                        sched.push_back('{6, 0, s, v, model_ch});
                        sched.push_back('{7, 0, 0, 0, nch});
                    end
                end
            end
        end
        model_ch = nch;
    endtask

    task automatic test_random();
        ent_t e;
        do_reset();
        sched.delete();
        model_ch = 0;
        model_frames = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (sched.size() == 0) push_frame();
            e = sched[0];
            en        = ($urandom_range(0, 4) != 0);
            out_ready = $urandom_range(0, 1);
            in_valid  = $urandom_range(0, 1);
            #1;
            vecs++;
            if (ostate !== e.st || tap_idx !== e.tap || stage_idx !== e.stg ||
                vector_idx !== e.vec || ch_idx !== e.ch ||
                mac_clr !== (e.st == 1 && en) || mac_en !== (e.st == 2 && en) ||
                out_valid !== (e.st == 5 && en) || in_ready !== (e.st == 6 && en)) begin
                errs++;
                $display("FAIL random[%0d]: st=%0d tap=%0d stg=%0d vec=%0d ch=%0d clr=%0b men=%0b ov=%0b ir=%0b, required st=%0d tap=%0d stg=%0d vec=%0d ch=%0d en=%0b",
                         cyc, ostate, tap_idx, stage_idx, vector_idx, ch_idx, mac_clr, mac_en,
                         out_valid, in_ready, e.st, e.tap, e.stg, e.vec, e.ch, en);
            end
`ifdef SRC_CTRL_FRAME_CNT_EN
            vecs++;
            if (frame_cnt !== model_frames) begin
                errs++;
                $display("FAIL random_frame[%0d]: frame_cnt=%0d, required %0d", cyc, frame_cnt, model_frames);
            end
`endif
            if (en) begin
                if (e.st == 5) begin
                    if (out_ready) void'(sched.pop_front());
                end else if (e.st == 6) begin
                    if (in_valid) begin
                        void'(sched.pop_front());
                        if (e.ch == C - 1) model_frames++;
                    end
                end else begin
                    void'(sched.pop_front());
                end
            end
            tick();
        end
        en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_stage_pass();
        test_out_backpressure();
        test_input_wait();
        test_enable_gating();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
